// File: rtl/boa_defines.sv
// Shared Boa32 definitions.
//
// boa_arb_owner_t names the two sides of a two-way bus arbiter. The memory
// arbiter uses it today, and a future cache/MMIO arbiter can reuse it.
// boa_req_active() is the one place that defines when a memory requester has
// a transaction pending.
package boa_defines;

    typedef enum logic {
        ARB_D = 1'b0,
        ARB_P = 1'b1
    } boa_arb_owner_t;

    // A requester is active on a read or on any byte-enabled write.
    function automatic logic boa_req_active(input logic re, input logic [3:0] we);
        return re || (we != 4'b0000);
    endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// Boa32 word-addressed memory bus.
//
// Request side (driven by the CPU-side requester):
//   re          read strobe
//   we[3:0]     byte write enables; any set bit makes this a write
//   addr[31:2]  word address; bits [1:0] are implicitly zero
//   wdata[31:0] write data, meaningful only while we != 0
// Response side (driven by the memory side):
//   ready       transaction completes this cycle
//   rdata[31:0] read data, valid with ready
//
// Modports:
//   CPU  the side that issues requests
//   MEM  the side that answers them
interface boa_mem_bus;

    logic        re;
    logic [3:0]  we;
    logic [31:2] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport CPU (
        output re,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport MEM (
        input  re,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );

endinterface

// File: rtl/boa_mem_arbiter.sv
// Round-robin arbiter that shares one memory bus between the Boa32 data port
// (dbus) and instruction-fetch port (pbus).
//
// Only one transaction is outstanding at a time. The winner of a free cycle
// drives mem combinationally in the same cycle, so arbitration adds no
// latency. ready/rdata return combinationally from mem to the current owner.
// A target that never answers is cut off after `timeout` cycles. The owner
// then gets a forced ready with rdata = 0 and a one-cycle error pulse.
//
// Parameters:
//   timeout  cycles a granted transaction may wait for mem.ready (0 = never)
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   dbus      data requester (this block answers it)
//   pbus      instruction requester (this block answers it)
//   mem       shared downstream bus (this block drives requests on it)
//   d_err     one-cycle pulse: a dbus transaction timed out
//   p_err     one-cycle pulse: a pbus transaction timed out
module boa_mem_arbiter
    import boa_defines::*;
#(
    parameter int unsigned timeout = 255
) (
    input  logic    clk,
    input  logic    rst,
    boa_mem_bus.MEM dbus,
    boa_mem_bus.MEM pbus,
    boa_mem_bus.CPU mem,
    output logic    d_err,
    output logic    p_err
);

    localparam logic StIdle = 1'b0;
    localparam logic StBusy = 1'b1;

    // The counter must reach `timeout` to saturate. Keep at least one bit so
    // that timeout = 0 still elaborates.
    localparam int unsigned     CntW    = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(timeout);
    localparam logic [CntW-1:0] CntLast = CntW'(timeout - 1);
    localparam logic            ToEn    = (timeout != 0);

    // The port that did not win last time wins a tie.
    function automatic boa_arb_owner_t rr_pick(input logic           d_req,
                                               input logic           p_req,
                                               input boa_arb_owner_t last);
        if (d_req && p_req) begin
            return (last == ARB_D) ? ARB_P : ARB_D;
        end else if (d_req) begin
            return ARB_D;
        end
        return ARB_P;
    endfunction

    logic            state_q, state_d;
    boa_arb_owner_t  owner_q, owner_d;
    boa_arb_owner_t  last_q,  last_d;
    logic [CntW-1:0] cnt_q,   cnt_d;

    logic           d_act;
    logic           p_act;
    logic           any_act;
    logic           busy;
    logic           to_hit;
    logic           done;
    logic           free_cyc;
    logic           drive;
    logic           resp;
    boa_arb_owner_t win;
    boa_arb_owner_t sel;
    logic [3:0]     sel_we;

    // Arbitration, bus steering and response routing
    always_comb begin
        d_act   = boa_req_active(dbus.re, dbus.we);
        p_act   = boa_req_active(pbus.re, pbus.we);
        any_act = d_act || p_act;
        busy    = (state_q == StBusy);

        // A real ready in the last allowed cycle beats the timeout.
        to_hit   = ToEn && busy && (cnt_q == CntLast) && !mem.ready;
        done     = busy && (mem.ready || to_hit);
        free_cyc = !busy || done;

        win = rr_pick(d_act, p_act, last_q);
        // In a free cycle the new winner owns mem. Otherwise the current
        // owner keeps it.
        sel = free_cyc ? win : owner_q;

        // Drive mem while a transaction continues, or when a free cycle has
        // someone to grant. Reset masks everything.
        drive  = !rst && (!free_cyc || any_act);
        sel_we = (sel == ARB_D) ? dbus.we : pbus.we;

        mem.re    = drive && ((sel == ARB_D) ? dbus.re : pbus.re);
        mem.we    = drive ? sel_we : 4'b0000;
        mem.addr  = (sel == ARB_D) ? dbus.addr : pbus.addr;
        mem.wdata = (sel_we != 4'b0000) ? ((sel == ARB_D) ? dbus.wdata : pbus.wdata) : 'x;

        // Completion goes to the owner of the finishing transaction. A stray
        // mem.ready while idle is never forwarded.
        resp       = !rst && done;
        dbus.ready = resp && (owner_q == ARB_D);
        pbus.ready = resp && (owner_q == ARB_P);
        dbus.rdata = to_hit ? 32'h0 : mem.rdata;
        pbus.rdata = to_hit ? 32'h0 : mem.rdata;

        d_err = !rst && to_hit && (owner_q == ARB_D);
        p_err = !rst && to_hit && (owner_q == ARB_P);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        if (free_cyc) begin
            cnt_d = '0;
            if (any_act) begin
                state_d = StBusy;
                owner_d = win;
                last_d  = win;
            end else begin
                state_d = StIdle;
            end
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Reset leaves last = P so that dbus wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= ARB_P;
            last_q  <= ARB_P;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/boa_mem_arbiter.md
# boa_mem_arbiter

Two-port arbiter that shares one memory bus between the instruction-fetch bus (`pbus`) and the data bus (`dbus`) of the Boa³² core. It sits between the pipeline and a single-ported memory or bus bridge. It grants one outstanding transaction at a time, with round-robin priority at every free bus cycle, and adds no latency to a granted request. It routes `ready`/`rdata` back to the owner and recovers from a hung target through a timeout counter.

## Interface
- `timeout`, default 255: cycles a granted transaction may wait for `mem.ready` before it is forcibly completed; 0 disables the timeout.
- `clk`  in  1  CPU clock.
- `rst`  in  1  synchronous, active-high reset.
- `dbus`  boa_mem_bus.MEM  -  data requester.
  - `re`/`we`[3:0] byte enables, `addr`[31:2], `wdata`[31:0] in.
  - `ready`, `rdata`[31:0] out.
- `pbus`  boa_mem_bus.MEM  -  instruction requester, same signals as `dbus`.
- `mem`  boa_mem_bus.CPU  -  shared downstream bus.
- `d_err`  out  1  one-cycle pulse: a `dbus` transaction timed out.
- `p_err`  out  1  one-cycle pulse: a `pbus` transaction timed out.

## Operation
- **Request.** A requester is active when `re || we != 0`. It holds `addr`/`we`/`wdata` stable until it sees `ready`.
- **State.** `state` ∈ {IDLE, BUSY}, plus `owner` ∈ {D, P}, `last` ∈ {D, P}, and a wait counter `cnt`.
- **Free cycle.** A cycle is free when state = IDLE, or state = BUSY and this cycle completes (`mem.ready` or timeout).
- **Arbitration.** Happens in every free cycle.
  - Only one requester active: it wins.
  - Both active: the one not equal to `last` wins.
  - Winner's signals drive `mem` combinationally in that same cycle. Next state is BUSY, `owner` = winner, `last` = winner, `cnt` = 0.
  - No requester active: `mem.re` = 0, `mem.we` = 0, next state IDLE.
- **BUSY, not completing.**
  - `mem` is driven from `owner`'s live signals.
  - The non-owner sees `ready` = 0.
  - `cnt` increments, saturating at `timeout`.
- **Completion.**
  - `owner.ready` = `mem.ready` && state = BUSY, combinationally.
  - `rdata` is forwarded to both ports. Only the owner's `ready` is ever asserted.
- **Back-to-back.** In a completion cycle the owner may present its next request. If the other port is also active, the other port wins; otherwise the owner keeps the bus with no bubble.
- **Timeout.** Triggers when `timeout` ≠ 0, state = BUSY and `cnt` = `timeout` - 1 with no `mem.ready`.
  - Owner gets `ready` = 1 and `rdata` = 0.
  - Matching `d_err`/`p_err` pulses for one cycle.
  - The cycle counts as free.
- **Addresses.** `mem.addr`[1:0] = 0. `mem.wdata` = `'bx` when the winner has `we` = 0.

## Timing
- **Reset values.**
  - state IDLE, `owner` = P, `last` = P (so `dbus` wins the first tie), `cnt` = 0.
  - During `rst`: `mem.re`/`mem.we` = 0, both `ready` = 0, `d_err`/`p_err` = 0, regardless of requests.
- **Reset mid-transaction.** Ownership is dropped; a late `mem.ready` after reset with state IDLE is ignored and not forwarded.
- **Latency.** 0 added cycles. The grant is seen on `mem` in the request cycle, and `ready` returns in the same cycle as `mem.ready`.
- **Fairness.** Under continuous contention, grants strictly alternate D, P, D, P.
- **Timeout latency.** Exactly `timeout` cycles from grant to forced `ready`.
- **Simultaneous `mem.ready` and timeout.** `mem.ready` wins; no error pulse.
- **Counter width.** `$clog2(timeout+1)` bits.

## Structure
- Add a `boa_arb_owner_t` enum {ARB_D, ARB_P} to the shared `boa_defines` package, for reuse by a future cache/MMIO arbiter.
- Implement as a single module, with no sub-modules. The round-robin pick is a small combinational function local to the module.

## Test plan
- **Reset and first tie.** Assert `rst`, both ports request → `mem.re` = 0. Release `rst`, both request → `dbus` granted, `mem.addr` = `dbus.addr` in the same cycle.
- **Contention.** `pbus` reads 0x4000_0000/4/8 continuously with `mem.ready` every cycle; `dbus` writes 0x1000_0000 (we = 4'hF, wdata 0xDEADBEEF) → grant order D, P, D, P with no idle bus cycle. The write reaches `mem` with correct `we`/`wdata`, and each `ready` goes only to the owner.
- **Back-to-back, single requester.** Only `pbus` active, `mem.ready` 1 cycle after each grant → one transaction per cycle with no bubble, and `rdata` 0x00000013 arrives on `pbus` with `ready`.
- **Timeout.** `timeout` = 4, `dbus` read, `mem.ready` never asserted → 4 cycles after the grant: `dbus.ready` = 1, `rdata` = 0, `d_err` pulses 1 cycle, and a pending `pbus` request is granted in that same cycle.
- **Reset mid-transaction.** `pbus` granted, `rst` pulsed before `mem.ready`, then `mem.ready` = 1 → no `ready` on either port, state IDLE.
- **Timeout/ready collision.** `mem.ready` arrives exactly in the timeout cycle → normal completion with `mem.rdata`, no error pulse.
